seven_seg_scan_decoder: RTL and testbench
=========================================

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, meaning consecutive identical cycles required before a digit is captured (range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 131072, meaning cycles without a capture after which a digit's vld is cleared (range > 2*STABLE_CYCLES, fits 18 bits).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 seg  input  7  segment lines, active-low; bit0=a ... bit6=g.
REQ-006 digit  input  2  digit select, one-hot active-high; 2'b10 selects digit 0, 2'b01 selects digit 1.
REQ-007 val0 / val1  output  4 each  last captured hex value of digit 0 / digit 1.
REQ-008 vld  output  2  bit n=1: digit n holds a fresh, recognised value.
REQ-009 blank  output  2  bit n=1: last capture of digit n was all-off (seg=7'b1111111).
REQ-010 err  output  2  bit n=1: last capture of digit n was an unrecognised pattern.
REQ-011 upd  output  2  bit n pulses high for one cycle when digit n is captured.

Function
REQ-012 Input sampling: seg and digit SHALL be registered once before use; all latencies below count from that register.
REQ-013 Decode table (seg, active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-014 Stability filter: a single counter SHALL increment each cycle the registered {digit,seg} equals its previous-cycle value, and SHALL reset to 0 on any change.
REQ-015 Capture: when the counter reaches STABLE_CYCLES-1 with digit one-hot, the selected digit SHALL be captured exactly once; the counter then saturates and no re-capture occurs until {digit,seg} changes.
REQ-016 Invalid select: digit=2'b00 or 2'b11 SHALL hold the counter at 0 and never capture.
REQ-017 Capture of a table pattern: valN<=decoded value, vld[N]<=1, blank[N]<=0, err[N]<=0.
REQ-018 Capture of 7'b1111111: valN unchanged, vld[N]<=0, blank[N]<=1, err[N]<=0.
REQ-019 Capture of any other pattern: valN unchanged, vld[N]<=0, blank[N]<=0, err[N]<=1.
REQ-020 upd[N] SHALL assert in the cycle the capture's results become visible and deassert the next cycle; upd SHALL never have both bits set.
REQ-021 Staleness: one timeout counter per digit, cleared on that digit's capture, saturating at TIMEOUT_CYCLES; on reaching TIMEOUT_CYCLES vld[N]<=0 (val, blank, err unchanged).
REQ-022 Simultaneous capture and timeout on the same digit: capture SHALL win, counter restarts at 0.
REQ-023 Latency: a new stable {digit,seg} presented at cycle t SHALL produce upd at cycle t+STABLE_CYCLES+1.
REQ-024 Digit captures SHALL be independent: capturing one digit SHALL never alter the other digit's outputs or timeout counter.

Reset
REQ-025 While rst_n=0 at a clock edge: val0=val1=0, vld=blank=err=upd=2'b00, stability counter=0, timeout counters=0, input register=7'b1111111/2'b00.
REQ-026 Reset asserted mid-filter SHALL discard partial counts; after release a full STABLE_CYCLES window is required before any capture.
REQ-027 Reset has no effect between clock edges; outputs change only on rising clk.

Verification
REQ-028 digit=2'b10, seg=7'b1111001 held 16 cycles after reset -> upd=2'b01 pulse at cycle 17, val0=1, vld=2'b01, val1=0.
REQ-029 Alternate digit 2'b10/seg=0100100 and 2'b01/seg=0001000 every 64 cycles -> val0=2, val1=A, vld=2'b11, one upd pulse per slot, never both bits.
REQ-030 seg toggled every 15 cycles with digit=2'b01 -> no upd, outputs unchanged.
REQ-031 digit=2'b10, seg=7'b1111111 stable, then seg=7'b0101010 stable -> blank=2'b01 then err=2'b01 with blank cleared, vld[0]=0 both times, val0 retained.
REQ-032 Capture digit 1, then digit=2'b00 for TIMEOUT_CYCLES cycles -> vld[1] drops to 0 exactly at timeout, val1 retained; digit=2'b11 input likewise yields no capture.
REQ-033 rst_n low for 1 cycle at filter count 10 -> all outputs 0, subsequent capture needs full 16 stable cycles.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: debounces a multiplexed two-digit active-low 7-segment bus
// and recovers each digit's hex value with blank/error/staleness flags.
module seven_seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [1:0] digit,
  output logic [3:0] val0,
  output logic [3:0] val1,
  output logic [1:0] vld,
  output logic [1:0] blank,
  output logic [1:0] err,
  output logic [1:0] upd
);
  localparam logic [7:0]  CAP_AT = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]  SAT    = 8'(STABLE_CYCLES);
  localparam logic [17:0] TMAX   = 18'(TIMEOUT_CYCLES);
  localparam logic [17:0] TLAST  = 18'(TIMEOUT_CYCLES - 1);
  logic [6:0] seg_r, seg_p;
  logic [1:0] dig_r, dig_p;
  logic [7:0] cnt;
  logic [1:0][17:0] tcnt;
  logic same, sel_ok, cap, hit, is_blank;
  logic [1:0] cap_v;
  logic [3:0] dval;
  always_comb begin
    same     = {dig_r, seg_r} == {dig_p, seg_p};
    sel_ok   = dig_r == 2'b10 || dig_r == 2'b01;
    cap      = sel_ok && same && cnt == CAP_AT;
    cap_v    = cap ? {dig_r[0], dig_r[1]} : 2'b00;
    is_blank = seg_r == 7'b1111111;
    hit      = 1'b1;
    dval     = 4'h0;
    case (seg_r)
      7'b1000000: dval = 4'h0;
      7'b1111001: dval = 4'h1;
      7'b0100100: dval = 4'h2;
      7'b0110000: dval = 4'h3;
      7'b0011001: dval = 4'h4;
      7'b0010010: dval = 4'h5;
      7'b0000010: dval = 4'h6;
      7'b1111000: dval = 4'h7;
      7'b0000000: dval = 4'h8;
      7'b0010000: dval = 4'h9;
      7'b0001000: dval = 4'hA;
      7'b0000011: dval = 4'hB;
      7'b1000110: dval = 4'hC;
      7'b0100001: dval = 4'hD;
      7'b0000110: dval = 4'hE;
      7'b0001110: dval = 4'hF;
      default:    hit  = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r <= 7'b1111111;
      seg_p <= 7'b1111111;
      dig_r <= 2'b00;
      dig_p <= 2'b00;
      cnt   <= '0;
      tcnt  <= '0;
      val0  <= '0;
      val1  <= '0;
      vld   <= '0;
      blank <= '0;
      err   <= '0;
      upd   <= '0;
    end else begin
      seg_r <= seg;
      dig_r <= digit;
      seg_p <= seg_r;
      dig_p <= dig_r;
      // saturating one past the capture point keeps a held pattern from re-capturing
      cnt   <= (!sel_ok || !same) ? '0 : (cnt == SAT ? cnt : cnt + 8'd1);
      upd   <= cap_v;
      val0  <= (cap_v[0] && hit) ? dval : val0;
      val1  <= (cap_v[1] && hit) ? dval : val1;
      for (int n = 0; n < 2; n++) begin
        if (cap_v[n]) begin
          tcnt[n]  <= '0;
          vld[n]   <= hit;
          blank[n] <= is_blank;
          err[n]   <= !hit && !is_blank;
        end else if (tcnt[n] != TMAX) begin
          tcnt[n] <= tcnt[n] + 18'd1;
          if (tcnt[n] == TLAST) vld[n] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: directed vector table plus latency, timeout and reset sequences.
module tb_seven_seg_scan_decoder;
  localparam int S = 16;
  localparam int T = 500;
  logic clk = 0, rst_n = 0;
  logic [6:0] seg = 7'b1111111;
  logic [1:0] digit = 2'b00;
  logic [3:0] val0, val1;
  logic [1:0] vld, blank, err, upd;
  int ncmp = 0, nbad = 0;

  seven_seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .digit(digit),
    .val0(val0), .val1(val1), .vld(vld), .blank(blank), .err(err), .upd(upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] d;
    logic [6:0] s;
    logic [3:0] v0, v1;
    logic [1:0] vl, bl, er;
    int u0, u1;
  } vec_t;
  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [3:0] v0, input logic [3:0] v1,
                          input logic [1:0] vl, input logic [1:0] bl, input logic [1:0] er);
    chk({nm, ".val0"}, 32'(val0), 32'(v0));
    chk({nm, ".val1"}, 32'(val1), 32'(v1));
    chk({nm, ".vld"}, 32'(vld), 32'(vl));
    chk({nm, ".blank"}, 32'(blank), 32'(bl));
    chk({nm, ".err"}, 32'(err), 32'(er));
  endtask

  int u0, u1, both;

  initial begin
    tv[0]  = '{2'b10, 7'b1111001, 4'h1, 4'h0, 2'b01, 2'b00, 2'b00, 1, 0};
    tv[1]  = '{2'b01, 7'b0001000, 4'h1, 4'hA, 2'b11, 2'b00, 2'b00, 0, 1};
    tv[2]  = '{2'b10, 7'b0100100, 4'h2, 4'hA, 2'b11, 2'b00, 2'b00, 1, 0};
    tv[3]  = '{2'b01, 7'b0000011, 4'h2, 4'hB, 2'b11, 2'b00, 2'b00, 0, 1};
    tv[4]  = '{2'b10, 7'b1111111, 4'h2, 4'hB, 2'b10, 2'b01, 2'b00, 1, 0};
    tv[5]  = '{2'b10, 7'b0101010, 4'h2, 4'hB, 2'b10, 2'b00, 2'b01, 1, 0};
    tv[6]  = '{2'b00, 7'b1000000, 4'h2, 4'hB, 2'b10, 2'b00, 2'b01, 0, 0};
    tv[7]  = '{2'b11, 7'b1000000, 4'h2, 4'hB, 2'b10, 2'b00, 2'b01, 0, 0};
    tv[8]  = '{2'b10, 7'b1000110, 4'hC, 4'hB, 2'b11, 2'b00, 2'b00, 1, 0};
    tv[9]  = '{2'b01, 7'b0000110, 4'hC, 4'hE, 2'b11, 2'b00, 2'b00, 0, 1};
    tv[10] = '{2'b01, 7'b1111111, 4'hC, 4'hE, 2'b01, 2'b10, 2'b00, 0, 1};
    tv[11] = '{2'b01, 7'b0010010, 4'hC, 4'h5, 2'b11, 2'b00, 2'b00, 0, 1};
    tv[12] = '{2'b10, 7'b0011001, 4'h4, 4'h5, 2'b11, 2'b00, 2'b00, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 4'h0, 4'h0, 2'b00, 2'b00, 2'b00);
    chk("reset.upd", 32'(upd), 32'd0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      digit = tv[i].d;
      seg = tv[i].s;
      u0 = 0; u1 = 0; both = 0;
      repeat (40) begin
        @(posedge clk); #1;
        u0 += int'(upd[0]);
        u1 += int'(upd[1]);
        both += int'(upd == 2'b11);
      end
      chk_outs($sformatf("vec%0d", i), tv[i].v0, tv[i].v1, tv[i].vl, tv[i].bl, tv[i].er);
      chk($sformatf("vec%0d.upd0", i), 32'(u0), 32'(tv[i].u0));
      chk($sformatf("vec%0d.upd1", i), 32'(u1), 32'(tv[i].u1));
      chk($sformatf("vec%0d.both", i), 32'(both), 32'd0);
    end

    // patterns changing every 15 cycles never become stable long enough
    u0 = 0; u1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      digit = 2'b01;
      seg = i[0] ? 7'b0100100 : 7'b1111001;
      repeat (15) begin
        @(posedge clk); #1;
        u0 += int'(upd[0]);
        u1 += int'(upd[1]);
      end
    end
    chk("toggle.upd", 32'(u0 + u1), 32'd0);
    chk_outs("toggle", 4'h4, 4'h5, 2'b11, 2'b00, 2'b00);

    // capture latency: upd appears on the (S+1)th edge after the sampling edge
    @(negedge clk);
    digit = 2'b10;
    seg = 7'b0000000;
    for (int k = 0; k <= S + 1; k++) begin
      @(posedge clk); #1;
      if (k < S + 1) chk($sformatf("lat.k%0d", k), 32'(upd), 32'd0);
      else chk("lat.upd", 32'(upd), 32'b01);
    end
    @(posedge clk); #1;
    chk("lat.upd_off", 32'(upd), 32'd0);
    chk("lat.val0", 32'(val0), 32'h8);

    // timeout on digit 1 while the bus carries no valid selection
    @(negedge clk);
    digit = 2'b01;
    seg = 7'b0110000;
    for (int k = 0; k <= S + 1; k++) begin
      @(posedge clk); #1;
    end
    chk("to.cap_upd", 32'(upd), 32'b10);
    chk("to.cap_val1", 32'(val1), 32'h3);
    digit = 2'b00;
    repeat (T - 1) @(posedge clk);
    #1;
    chk("to.before", 32'(vld), 32'b10);
    @(posedge clk); #1;
    chk("to.at", 32'(vld), 32'b00);
    chk("to.val1", 32'(val1), 32'h3);
    @(negedge clk);
    digit = 2'b11;
    u0 = 0;
    repeat (40) begin
      @(posedge clk); #1;
      u0 += int'(upd != 2'b00);
    end
    chk("sel11.upd", 32'(u0), 32'd0);
    chk_outs("sel11", 4'h8, 4'h3, 2'b00, 2'b00, 2'b00);

    // reset in the middle of a filter window discards the partial count
    @(negedge clk);
    digit = 2'b10;
    seg = 7'b1111000;
    repeat (11) @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk); #1;
    chk_outs("midrst", 4'h0, 4'h0, 2'b00, 2'b00, 2'b00);
    chk("midrst.upd", 32'(upd), 32'd0);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k <= S + 1; k++) begin
      @(posedge clk); #1;
      if (k < S + 1) chk($sformatf("rst.k%0d", k), 32'(upd), 32'd0);
      else chk("rst.upd", 32'(upd), 32'b01);
    end
    chk_outs("rst.cap", 4'h7, 4'h0, 2'b01, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
